// File: rtl/lcd_ctrl_gen_if.sv
// Bus bundle between the LCD controller and its host, image ROM and image RAM.
// Widths follow the image geometry: AW = 2*LOG_W address bits, DW data bits.
interface lcd_ctrl_gen_if #(
    parameter int LOG_W = 3,
    parameter int DW    = 8
);
    localparam int AW = 2 * LOG_W;

    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          IROM_rd;
    logic [AW-1:0] IROM_A;
    logic [DW-1:0] IROM_Q;
    logic          IRAM_valid;
    logic [AW-1:0] IRAM_A;
    logic [DW-1:0] IRAM_D;
    logic          busy;
    logic          done;

    modport master (
        input  cmd, cmd_valid, IROM_Q,
        output IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done
    );

    modport slave (
        output cmd, cmd_valid, IROM_Q,
        input  IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done
    );
endinterface

// File: rtl/lcd_ctrl_gen.sv
// Parametrised LCD image controller: loads a W x W image from ROM, applies 2x2
// window commands around a movable operation point, then streams the image to RAM.
module lcd_ctrl_gen #(
    parameter int LOG_W = 3,
    parameter int DW    = 8,
    parameter int AW    = 2 * LOG_W
) (
    input  logic           clk,
    input  logic           reset,
    lcd_ctrl_gen_if.master bus
);
    localparam int W    = 1 << LOG_W;
    localparam int NPIX = W * W;
    localparam logic [LOG_W-1:0] HOME_C    = LOG_W'(W / 2);
    localparam logic [LOG_W-1:0] LAST_C    = LOG_W'(W - 1);
    localparam logic [LOG_W-1:0] ONE_C     = LOG_W'(1);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(NPIX - 1);
    localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] avg4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic [DW+1:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[DW+1:2];
    endfunction

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rom_rd_q, rom_rd_d;
    logic [AW-1:0]      rom_a_q, rom_a_d;
    logic               ram_valid_q, ram_valid_d;
    logic [AW-1:0]      ram_a_q, ram_a_d;
    logic [DW-1:0]      ram_d_q, ram_d_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [LOG_W-1:0]   px_q, px_d, py_q, py_d;
    logic [DW-1:0]      pix_q [NPIX];
    logic [DW-1:0]      pix_d [NPIX];

    logic [LOG_W-1:0]   px_m1_s, py_m1_s;
    logic [AW-1:0]      tl_a_s, tr_a_s, bl_a_s, br_a_s, ram_a_nxt_s;
    logic [DW-1:0]      tl_s, tr_s, bl_s, br_s, wmax_s, wmin_s, wavg_s;

    // Window addresses are {row, column} because W is a power of two.
    assign px_m1_s     = px_q - ONE_C;
    assign py_m1_s     = py_q - ONE_C;
    assign tl_a_s      = {py_m1_s, px_m1_s};
    assign tr_a_s      = {py_m1_s, px_q};
    assign bl_a_s      = {py_q, px_m1_s};
    assign br_a_s      = {py_q, px_q};
    assign ram_a_nxt_s = ram_a_q + ADDR_ONE;
    assign tl_s        = pix_q[tl_a_s];
    assign tr_s        = pix_q[tr_a_s];
    assign bl_s        = pix_q[bl_a_s];
    assign br_s        = pix_q[br_a_s];
    assign wmax_s      = max2(max2(tl_s, tr_s), max2(bl_s, br_s));
    assign wmin_s      = min2(min2(tl_s, tr_s), min2(bl_s, br_s));
    assign wavg_s      = avg4(tl_s, tr_s, bl_s, br_s);

    // Next-state, buffer update and output computation.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        rom_rd_d    = rom_rd_q;
        rom_a_d     = rom_a_q;
        ram_valid_d = ram_valid_q;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        cmd_d       = cmd_q;
        px_d        = px_q;
        py_d        = py_q;
        pix_d       = pix_q;
        case (state_q)
            S_LOAD: begin
                if (rom_rd_q) begin
                    pix_d[rom_a_q] = bus.IROM_Q;
                    if (rom_a_q == ADDR_LAST) begin
                        rom_rd_d = 1'b0;
                        rom_a_d  = '0;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        rom_a_d = rom_a_q + ADDR_ONE;
                    end
                end else begin
                    rom_rd_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d   = bus.cmd;
                    busy_d  = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (cmd_q == 4'h0) begin
                    state_d     = S_WRITE;
                    ram_valid_d = 1'b1;
                    ram_a_d     = '0;
                    ram_d_d     = pix_q[0];
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    case (cmd_q)
                        4'h1: py_d = (py_q > ONE_C)   ? py_m1_s : py_q;
                        4'h2: py_d = (py_q != LAST_C) ? py_q + ONE_C : py_q;
                        4'h3: px_d = (px_q > ONE_C)   ? px_m1_s : px_q;
                        4'h4: px_d = (px_q != LAST_C) ? px_q + ONE_C : px_q;
                        4'h5: begin
                            pix_d[tl_a_s] = wmax_s; pix_d[tr_a_s] = wmax_s;
                            pix_d[bl_a_s] = wmax_s; pix_d[br_a_s] = wmax_s;
                        end
                        4'h6: begin
                            pix_d[tl_a_s] = wmin_s; pix_d[tr_a_s] = wmin_s;
                            pix_d[bl_a_s] = wmin_s; pix_d[br_a_s] = wmin_s;
                        end
                        4'h7: begin
                            pix_d[tl_a_s] = wavg_s; pix_d[tr_a_s] = wavg_s;
                            pix_d[bl_a_s] = wavg_s; pix_d[br_a_s] = wavg_s;
                        end
                        4'h8: begin
                            pix_d[tl_a_s] = tr_s; pix_d[tr_a_s] = br_s;
                            pix_d[br_a_s] = bl_s; pix_d[bl_a_s] = tl_s;
                        end
                        4'h9: begin
                            pix_d[tl_a_s] = bl_s; pix_d[bl_a_s] = br_s;
                            pix_d[br_a_s] = tr_s; pix_d[tr_a_s] = tl_s;
                        end
                        4'hA: begin
                            pix_d[tl_a_s] = bl_s; pix_d[bl_a_s] = tl_s;
                            pix_d[tr_a_s] = br_s; pix_d[br_a_s] = tr_s;
                        end
                        4'hB: begin
                            pix_d[tl_a_s] = tr_s; pix_d[tr_a_s] = tl_s;
                            pix_d[bl_a_s] = br_s; pix_d[br_a_s] = bl_s;
                        end
                        4'hC: begin
                            px_d = HOME_C;
                            py_d = HOME_C;
                        end
                        4'hD: begin
                            pix_d[tl_a_s] = ~tl_s; pix_d[tr_a_s] = ~tr_s;
                            pix_d[bl_a_s] = ~bl_s; pix_d[br_a_s] = ~br_s;
                        end
                        default: begin
                            px_d = px_q;
                            py_d = py_q;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (ram_a_q == ADDR_LAST) begin
                    ram_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    ram_a_d = ram_a_nxt_s;
                    ram_d_d = pix_q[ram_a_nxt_s];
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control and output registers; reset restarts the load from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_a_q     <= '0;
            ram_valid_q <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            cmd_q       <= 4'h0;
            px_q        <= HOME_C;
            py_q        <= HOME_C;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rom_rd_q    <= rom_rd_d;
            rom_a_q     <= rom_a_d;
            ram_valid_q <= ram_valid_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            cmd_q       <= cmd_d;
            px_q        <= px_d;
            py_q        <= py_d;
        end
    end

    // Pixel buffer; always reloaded after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        pix_q <= pix_d;
    end

    assign bus.IROM_rd    = rom_rd_q;
    assign bus.IROM_A     = rom_a_q;
    assign bus.IRAM_valid = ram_valid_q;
    assign bus.IRAM_A     = ram_a_q;
    assign bus.IRAM_D     = ram_d_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen: an 8x8/8-bit instance and a 16x16/10-bit
// instance, each fed from a bench ROM array with its RAM writes captured.
module tb_lcd_ctrl_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_ctrl_gen_if #(.LOG_W(3), .DW(8))  if8 ();
    lcd_ctrl_gen_if #(.LOG_W(4), .DW(10)) if16 ();

    lcd_ctrl_gen #(.LOG_W(3), .DW(8))  u8  (.clk(clk), .reset(reset), .bus(if8));
    lcd_ctrl_gen #(.LOG_W(4), .DW(10)) u16 (.clk(clk), .reset(reset), .bus(if16));

    logic [7:0] rom8 [64];
    logic [7:0] ram8 [64];
    logic [7:0] exp8 [64];
    logic [9:0] rom16 [256];
    logic [9:0] ram16 [256];
    logic [9:0] exp16 [256];

    assign if8.IROM_Q  = rom8[if8.IROM_A];
    assign if16.IROM_Q = rom16[if16.IROM_A];

    int n_cmp = 0;
    int n_err = 0;
    int ld8, wr8, ld16, wr16;
    bit ldbad8, wrbad8, ldbad16, wrbad16;

    // Capture ROM read order and RAM writes of both instances.
    always @(negedge clk) begin
        if (reset) begin
            ld8 = 0; wr8 = 0; ld16 = 0; wr16 = 0;
            ldbad8 = 1'b0; wrbad8 = 1'b0; ldbad16 = 1'b0; wrbad16 = 1'b0;
        end else begin
            if (if8.IROM_rd) begin
                if (int'(if8.IROM_A) != ld8) ldbad8 = 1'b1;
                ld8++;
            end
            if (if8.IRAM_valid) begin
                if (int'(if8.IRAM_A) != wr8) wrbad8 = 1'b1;
                ram8[if8.IRAM_A] = if8.IRAM_D;
                wr8++;
            end
            if (if16.IROM_rd) begin
                if (int'(if16.IROM_A) != ld16) ldbad16 = 1'b1;
                ld16++;
            end
            if (if16.IRAM_valid) begin
                if (int'(if16.IRAM_A) != wr16) wrbad16 = 1'b1;
                ram16[if16.IRAM_A] = if16.IRAM_D;
                wr16++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if8.cmd_valid = 1'b0;
        if16.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle(input bit big);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ((big ? if16.busy : if8.busy) == 1'b0) break;
        end
        chk("idle", big ? if16.busy : if8.busy, 0);
    endtask

    task automatic send(input bit big, input logic [3:0] c);
        wait_idle(big);
        if (big) begin
            if16.cmd = c; if16.cmd_valid = 1'b1;
        end else begin
            if8.cmd = c; if8.cmd_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if8.cmd_valid = 1'b0;
        if16.cmd_valid = 1'b0;
    endtask

    task automatic write_out(input bit big);
        send(big, 4'h0);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ((big ? if16.done : if8.done) == 1'b1) break;
        end
        #1;
        chk("wr_done", big ? if16.done : if8.done, 1);
        chk("wr_busy", big ? if16.busy : if8.busy, 1);
        chk("wr_valid_off", big ? if16.IRAM_valid : if8.IRAM_valid, 0);
        chk("wr_count", big ? wr16 : wr8, big ? 256 : 64);
        chk("wr_order", big ? wrbad16 : wrbad8, 0);
    endtask

    task automatic cmp8(input string tag);
        for (int a = 0; a < 64; a++) chk($sformatf("%s[%0d]", tag, a), ram8[a], exp8[a]);
    endtask

    task automatic cmp16(input string tag);
        for (int a = 0; a < 256; a++) chk($sformatf("%s[%0d]", tag, a), ram16[a], exp16[a]);
    endtask

    // Window at home (4,4): TL=27, TR=28, BL=35, BR=36 hold 10, 20, 30, 41.
    task automatic run_win(input string tag, input logic [3:0] c1, input logic [3:0] c2,
                           input logic [7:0] e_tl, input logic [7:0] e_tr,
                           input logic [7:0] e_bl, input logic [7:0] e_br);
        do_reset();
        send(1'b0, c1);
        send(1'b0, c2);
        write_out(1'b0);
        exp8 = rom8;
        exp8[27] = e_tl; exp8[28] = e_tr; exp8[35] = e_bl; exp8[36] = e_br;
        cmp8(tag);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) rom8[a] = 8'(a);
        for (int a = 0; a < 256; a++) rom16[a] = 10'(a);
        if8.cmd = 4'h0;  if8.cmd_valid = 1'b0;
        if16.cmd = 4'h0; if16.cmd_valid = 1'b0;

        // Reset values.
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", if8.busy, 1);
        chk("rst_done", if8.done, 0);
        chk("rst_rom_rd", if8.IROM_rd, 0);
        chk("rst_ram_valid", if8.IRAM_valid, 0);
        chk("rst_rom_a", if8.IROM_A, 0);
        chk("rst_ram_a", if8.IRAM_A, 0);
        chk("rst_ram_d", if8.IRAM_D, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Ramp load; an INVERT offered during load must be dropped.
        repeat (5) @(negedge clk);
        if8.cmd = 4'hD; if8.cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        if8.cmd_valid = 1'b0;
        wait_idle(1'b0);
        #1;
        chk("load_count", ld8, 64);
        chk("load_order", ldbad8, 0);
        write_out(1'b0);
        exp8 = rom8;
        cmp8("ramp");
        @(negedge clk);
        if8.cmd = 4'h4; if8.cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 if8.cmd_valid = 1'b0;
        chk("done_hold", if8.done, 1);
        chk("done_busy", if8.busy, 1);
        chk("done_no_wr", if8.IRAM_valid, 0);

        // Five rights clamp at px=7; MAX on {30,31,38,39}; left, down, MIN on {37,38,45,46}.
        do_reset();
        repeat (5) send(1'b0, 4'h4);
        send(1'b0, 4'h5);
        send(1'b0, 4'h3);
        send(1'b0, 4'h2);
        send(1'b0, 4'h6);
        write_out(1'b0);
        exp8 = rom8;
        exp8[30] = 8'd39; exp8[31] = 8'd39; exp8[38] = 8'd39; exp8[39] = 8'd39;
        exp8[37] = 8'd37; exp8[38] = 8'd37; exp8[45] = 8'd37; exp8[46] = 8'd37;
        cmp8("maxmin");

        // Shift up to the top edge, invert, HOME, invert, then reserved opcodes.
        do_reset();
        repeat (6) send(1'b0, 4'h1);
        send(1'b0, 4'hD);
        send(1'b0, 4'hC);
        send(1'b0, 4'hD);
        send(1'b0, 4'hE);
        chk("noop_busy_hi", if8.busy, 1);
        @(posedge clk);
        #1;
        chk("noop_busy_lo", if8.busy, 0);
        send(1'b0, 4'hF);
        write_out(1'b0);
        exp8 = rom8;
        exp8[3]  = 8'd252; exp8[4]  = 8'd251; exp8[11] = 8'd244; exp8[12] = 8'd243;
        exp8[27] = 8'd228; exp8[28] = 8'd227; exp8[35] = 8'd220; exp8[36] = 8'd219;
        cmp8("upinv");

        rom8[27] = 8'd10; rom8[28] = 8'd20; rom8[35] = 8'd30; rom8[36] = 8'd41;
        run_win("avg",    4'h7, 4'hE,  8'd25,  8'd25,  8'd25,  8'd25);
        run_win("cw",     4'h9, 4'hE,  8'd30,  8'd10,  8'd41,  8'd20);
        run_win("invert", 4'hD, 4'hE, 8'd245, 8'd235, 8'd225, 8'd214);
        run_win("ccw",    4'h8, 4'hE,  8'd20,  8'd41,  8'd10,  8'd30);
        run_win("mirror", 4'hA, 4'hB,  8'd41,  8'd30,  8'd20,  8'd10);

        // Reset in the middle of WRITE.
        do_reset();
        send(1'b0, 4'h0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if8.IRAM_valid && if8.IRAM_A == 6'd20) break;
        end
        chk("mid_wr_addr", if8.IRAM_A, 20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_valid", if8.IRAM_valid, 0);
        chk("abort_busy", if8.busy, 1);
        chk("abort_done", if8.done, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reload_rd", if8.IROM_rd, 1);
        chk("reload_a", if8.IROM_A, 0);
        wait_idle(1'b0);
        #1;
        chk("reload_done", if8.done, 0);
        chk("reload_count", ld8, 64);

        // 16x16, 10-bit: AVG of four 1023s at home, then MAX at the (15,15) corner.
        rom16[119] = 10'd1023; rom16[120] = 10'd1023;
        rom16[135] = 10'd1023; rom16[136] = 10'd1023;
        do_reset();
        wait_idle(1'b1);
        #1;
        chk("big_load_count", ld16, 256);
        chk("big_load_order", ldbad16, 0);
        send(1'b1, 4'h7);
        repeat (8) send(1'b1, 4'h4);
        repeat (8) send(1'b1, 4'h2);
        send(1'b1, 4'h5);
        write_out(1'b1);
        exp16 = rom16;
        exp16[238] = 10'd255; exp16[239] = 10'd255; exp16[254] = 10'd255; exp16[255] = 10'd255;
        cmp16("big_max");

        do_reset();
        repeat (8) send(1'b1, 4'h4);
        repeat (8) send(1'b1, 4'h2);
        send(1'b1, 4'h6);
        write_out(1'b1);
        exp16 = rom16;
        exp16[238] = 10'd238; exp16[239] = 10'd238; exp16[254] = 10'd238; exp16[255] = 10'd238;
        cmp16("big_min");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
